paralelo_serial_phy_tx: RTL and testbench

Transmit-side PHY serializer, the counterpart of the lane receiver. Accepts 8-bit bytes over a valid/ready handshake and shifts them out MSB-first, one bit per `clk_32f` cycle. After reset it emits a fixed burst of comma bytes (0xBC) so the receiver can align and raise `active`. It fills every gap in payload with commas, so the serial line never stalls.

---
 rtl/paralelo_serial_phy_tx_pkg.sv | 17 +
 rtl/shift_piso8.sv | 28 ++
 rtl/paralelo_serial_phy_tx.sv | 86 ++++++++
 tb/tb_paralelo_serial_phy_tx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/paralelo_serial_phy_tx_pkg.sv
// Shared PHY constants for the serializer (same values the lane receiver uses)
// and the byte-selection rule applied at every byte boundary.
package paralelo_serial_phy_tx_pkg;

  localparam logic [7:0] PHY_COMMA      = 8'hBC;
  localparam int         PHY_SYNC_BYTES = 4;
  localparam int         PHY_BYTE_BITS  = 8;

  // Payload wins only once aligned and a byte is waiting; otherwise the line idles.
  function automatic logic [7:0] next_line_byte(input logic       run,
                                                input logic       full,
                                                input logic [7:0] held,
                                                input logic [7:0] idle);
    return (run && full) ? held : idle;
  endfunction

endpackage

// File: rtl/shift_piso8.sv
// 8-bit parallel-in/serial-out register; q is the MSB, zeros shift in from the LSB.
module shift_piso8
  import paralelo_serial_phy_tx_pkg::*;
#(
  parameter logic [7:0] RST_VAL = PHY_COMMA
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] d,
  output logic       q
);

  logic [7:0] r_shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_reg <= RST_VAL;
    end else if (load) begin
      r_shift_reg <= d;
    end else begin
      r_shift_reg <= {r_shift_reg[6:0], 1'b0};
    end
  end

  assign q = r_shift_reg[7];

endmodule

// File: rtl/paralelo_serial_phy_tx.sv
// Transmit PHY serializer: comma burst after reset, then payload bytes MSB-first
// with commas filling every gap so the serial line never stalls.
module paralelo_serial_phy_tx
  import paralelo_serial_phy_tx_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE  = PHY_COMMA,
  parameter int         SYNC_BYTES = PHY_SYNC_BYTES
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       sending_data,
  output logic       synced
);

  localparam int         SYNC_W   = $clog2(SYNC_BYTES + 1);
  localparam logic [2:0] LAST_BIT = 3'(PHY_BYTE_BITS - 1);

  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_hold;
  logic              r_hold_full;
  logic [SYNC_W-1:0] r_sync_cnt;
  logic              r_synced;
  logic              r_sending;

  logic       w_boundary;
  logic       w_accept;
  logic [7:0] w_next_byte;

  assign w_boundary  = (r_bit_cnt == LAST_BIT);
  // A full hold frees itself on the boundary edge, so a new byte may enter then.
  assign ready_out   = r_synced & (~r_hold_full | w_boundary);
  assign w_accept    = valid_in & ready_out;
  assign w_next_byte = next_line_byte(r_synced, r_hold_full, r_hold, IDLE_BYTE);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_bit_cnt   <= '0;
      r_hold_full <= 1'b0;
      r_sync_cnt  <= '0;
      r_synced    <= 1'b0;
      r_sending   <= 1'b0;
    end else begin
      r_bit_cnt <= w_boundary ? 3'd0 : r_bit_cnt + 3'd1;
      if (w_boundary) begin
        if (!r_synced) begin
          r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
          if (r_sync_cnt == SYNC_W'(SYNC_BYTES - 1)) begin
            r_synced <= 1'b1;
          end
        end else begin
          r_sending <= r_hold_full;
        end
      end
      if (w_accept) begin
        r_hold_full <= 1'b1;
      end else if (w_boundary && r_synced) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  // Hold data carries no reset; r_hold_full alone says whether it is meaningful.
  always_ff @(posedge clk_32f) begin
    if (w_accept) begin
      r_hold <= data_in;
    end
  end

  shift_piso8 #(
    .RST_VAL (IDLE_BYTE)
  ) u_shift (
    .clk   (clk_32f),
    .rst_n (reset_L),
    .load  (w_boundary),
    .d     (w_next_byte),
    .q     (data_out)
  );

  assign sending_data = r_sending;
  assign synced       = r_synced;

endmodule

// File: tb/tb_paralelo_serial_phy_tx.sv
// Self-checking bench for paralelo_serial_phy_tx: byte-slot reference model of the serial line.
module tb_paralelo_serial_phy_tx;

  localparam int SYNC  = 4;
  localparam int NSLOT = 512;

  logic       clk_32f  = 1'b0;
  logic       reset_L  = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       sending_data;
  logic       synced;

  int errors = 0;
  int checks = 0;
  int e      = 0;
  int slots[NSLOT];

  paralelo_serial_phy_tx dut (
    .clk_32f      (clk_32f),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .sending_data (sending_data),
    .synced       (synced)
  );

  always #5 clk_32f = ~clk_32f;

  // Line model: after edge n (n edges since reset release) byte slot n/8 is on the
  // wire. A byte accepted on edge n is sent in slot n/8+1; empty slots carry 0xBC.
  function automatic bit slot_payload(input int s);
    return (s >= 0 && s < NSLOT) ? (slots[s] >= 0) : 1'b0;
  endfunction

  function automatic logic [7:0] slot_val(input int s);
    logic [7:0] v;
    v = 8'hBC;
    if (slot_payload(s)) v = slots[s][7:0];
    return v;
  endfunction

  function automatic bit model_ready(input int en);
    return (en > 8 * SYNC) && !slot_payload(en / 8 + 1);
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at edge %0d", tag, obs, exp, e);
    end
  endtask

  task automatic cycle(output bit acc);
    logic [7:0] b;
    @(negedge clk_32f);
    b = slot_val(e / 8);
    check_bit("data_out", data_out, b[7 - (e % 8)]);
    check_bit("sending_data", sending_data, slot_payload(e / 8));
    check_bit("synced", synced, e >= 8 * SYNC);
    check_bit("ready_out", ready_out, model_ready(e + 1));
    @(posedge clk_32f);
    acc = valid_in && model_ready(e + 1);
    e++;
    if (acc && (e / 8 + 1) < NSLOT) slots[e / 8 + 1] = int'(data_in);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    check_bit("rst_data_out", data_out, 1'b1);
    check_bit("rst_ready_out", ready_out, 1'b0);
    check_bit("rst_sending_data", sending_data, 1'b0);
    check_bit("rst_synced", synced, 1'b0);
    e = 0;
    for (int i = 0; i < NSLOT; i++) slots[i] = -1;
    repeat (2) @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep_valid);
    bit acc;
    int n;
    acc      = 1'b0;
    n        = 0;
    valid_in = 1'b1;
    data_in  = b;
    while (!acc && n < 64) begin
      cycle(acc);
      n++;
    end
    checks++;
    assert (acc)
    else begin
      errors++;
      $error("FAIL accept_timeout: byte %h observed=not_accepted expected=accepted", b);
    end
    if (!keep_valid) valid_in = 1'b0;
  endtask

  initial begin
    bit acc;
    acc = 1'b0;
    #3;
    do_reset();
    idle(64);

    // single byte offered mid-byte
    idle(3);
    send_byte(8'hA5, 1'b0);
    idle(20);

    // back-to-back with valid held high
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b0);
    idle(24);

    // payload equal to the comma
    send_byte(8'hBC, 1'b0);
    idle(20);

    // acceptance on a boundary edge with an empty hold
    while ((e + 1) % 8 != 0) cycle(acc);
    send_byte(8'h3C, 1'b0);
    idle(20);

    // reset at bit 3 of 0x5A with 0x77 pending
    send_byte(8'h5A, 1'b1);
    send_byte(8'h77, 1'b0);
    idle(3);
    do_reset();
    idle(40);
    send_byte(8'hC3, 1'b0);
    idle(20);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!valid_in || acc) begin
        valid_in = ($urandom_range(0, 2) != 0);
        data_in  = 8'($urandom);
      end
      cycle(acc);
    end
    valid_in = 1'b0;
    idle(24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
